// File: rtl/ahb_arbiter_rr.sv
// ahb_arbiter_rr: round-robin AHB arbiter for NUM_MASTERS masters.
// Holds the grant through locked sequences and masks SPLIT masters until
// their slave releases them via HSPLIT.
// Optional feature macro: AHB_ARB_BURST_HOLD_EN. When it is defined, the grant
// is also held for the length of fixed-length bursts (WRAP4..INCR16).
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  input  logic [15:0]            HSPLIT,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] RSP_SPLIT = 2'b11;
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

`ifdef AHB_ARB_BURST_HOLD_EN
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RSP_OKAY  = 2'b00;

  typedef enum logic [1:0] {ST_ARB, ST_LOCKED, ST_BURST} state_t;
`else
  typedef enum logic [1:0] {ST_ARB, ST_LOCKED} state_t;
`endif

  state_t                   state_reg, state_next;
  logic [NUM_MASTERS-1:0]   grant_reg, grant_next;
  logic [MW-1:0]            ptr_reg, ptr_next;
  logic [NUM_MASTERS-1:0]   split_mask_reg, split_mask_next;
  logic [MW-1:0]            hmaster_reg;
  logic                     mastlock_reg;

  logic [NUM_MASTERS-1:0]   eligible;
  logic [MW-1:0]            owner_idx;
  logic                     owner_lock;
  logic                     owner_hold;
  logic [MW-1:0]            winner_idx;
  logic [NUM_MASTERS-1:0]   winner_oh;
  logic                     winner_found;
  logic                     winner_lock;
  logic                     split_set;
  logic                     arbitrate;

`ifdef AHB_ARB_BURST_HOLD_EN
  logic [3:0] beat_cnt_reg, beat_cnt_next;
  logic       burst_start;
  logic [3:0] burst_len_m1;

  assign burst_start = (HTRANS == TR_NONSEQ) && (HBURST >= 3'd2);

  // Remaining beats after the NONSEQ beat for the fixed-length burst types
  always_comb begin
    case (HBURST[2:1])
      2'b01:   burst_len_m1 = 4'd3;
      2'b10:   burst_len_m1 = 4'd7;
      2'b11:   burst_len_m1 = 4'd15;
      default: burst_len_m1 = 4'd0;
    endcase
  end
`else
  logic unused_hburst;
  assign unused_hburst = ^HBURST;
`endif

  if (NUM_MASTERS < 16) begin : g_hsplit_unused
    logic unused_hsplit;
    assign unused_hsplit = ^HSPLIT[15:NUM_MASTERS];
  end

  assign eligible  = HBUSREQ & ~split_mask_reg;
  assign split_set = (HRESP == RSP_SPLIT) && !HREADY;

  // The grant is one-hot, so masking with it picks out the granted master's bits
  assign owner_lock  = |(grant_reg & HLOCK);
  assign owner_hold  = |(grant_reg & HLOCK & eligible);
  assign winner_lock = |(winner_oh & HLOCK & eligible);

  // Encode the currently granted master
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_reg[i]) owner_idx = MW'(i);
    end
  end

  // Round-robin search: indices above the last winner first, then wrap around
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = DEF_IDX;
    winner_oh    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!winner_found && eligible[i] && (i > int'(ptr_reg))) begin
        winner_found = 1'b1;
        winner_idx   = MW'(i);
        winner_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!winner_found && eligible[i] && (i <= int'(ptr_reg))) begin
        winner_found = 1'b1;
        winner_idx   = MW'(i);
        winner_oh[i] = 1'b1;
      end
    end
    if (!winner_found) winner_oh = DEF_OH;
  end

  // Split mask: a new SPLIT on the data-phase owner beats a release in the same cycle
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_split
    assign split_mask_next[gi] = (split_set && (hmaster_reg == MW'(gi))) ? 1'b1 :
                                 HSPLIT[gi]                              ? 1'b0 :
                                                                           split_mask_reg[gi];
  end

  // Next state, grant and pointer; nothing moves while HREADY is low except aborts
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    arbitrate  = 1'b0;
`ifdef AHB_ARB_BURST_HOLD_EN
    beat_cnt_next = beat_cnt_reg;
`endif
    if (HREADY) begin
      case (state_reg)
        ST_LOCKED: arbitrate = (HTRANS == TR_IDLE) && !owner_lock;
`ifdef AHB_ARB_BURST_HOLD_EN
        ST_BURST: begin
          if ((HRESP != RSP_OKAY) || (HTRANS == TR_IDLE) || (HTRANS == TR_NONSEQ)) begin
            arbitrate = 1'b1;
          end else if (HTRANS == TR_SEQ) begin
            // The beat that takes the count to zero is the last one; hand over during it
            beat_cnt_next = (beat_cnt_reg == 4'd0) ? 4'd0 : beat_cnt_reg - 4'd1;
            arbitrate     = (beat_cnt_reg <= 4'd1);
          end
        end
`endif
        default: arbitrate = 1'b1;
      endcase

      if (arbitrate) begin
        if (owner_hold) begin
          state_next = ST_LOCKED;
`ifdef AHB_ARB_BURST_HOLD_EN
        end else if (burst_start) begin
          state_next    = ST_BURST;
          beat_cnt_next = burst_len_m1;
`endif
        end else begin
          grant_next = winner_oh;
          state_next = winner_lock ? ST_LOCKED : ST_ARB;
          if (winner_idx != owner_idx) ptr_next = winner_idx;
        end
      end
    end else begin
      if (split_set) state_next = ST_ARB;
`ifdef AHB_ARB_BURST_HOLD_EN
      if ((state_reg == ST_BURST) && (HRESP != RSP_OKAY)) state_next = ST_ARB;
`endif
    end
  end

  // State registers and address-phase handover of HMASTER/HMASTLOCK
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg      <= ST_ARB;
      grant_reg      <= DEF_OH;
      ptr_reg        <= '0;
      split_mask_reg <= '0;
      hmaster_reg    <= DEF_IDX;
      mastlock_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      ptr_reg        <= ptr_next;
      split_mask_reg <= split_mask_next;
      if (HREADY) begin
        hmaster_reg  <= owner_idx;
        mastlock_reg <= owner_lock;
      end
    end
  end

`ifdef AHB_ARB_BURST_HOLD_EN
  // Beat counter for the burst hold
  always_ff @(posedge HCLK) begin
    if (HRESET) beat_cnt_reg <= 4'd0;
    else        beat_cnt_reg <= beat_cnt_next;
  end
`endif

  assign HGRANT    = grant_reg;
  assign HMASTER   = hmaster_reg;
  assign HMASTLOCK = mastlock_reg;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// tb_ahb_arbiter_rr: directed table of per-cycle vectors with hand-computed
// grant/owner/lock expectations, plus hand-written split-collision and
// reset-during-lock sequences.
module tb_ahb_arbiter_rr;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SPLIT = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [3:0]  hbusreq, hlock;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hready;
  logic [1:0]  hresp;
  logic [15:0] hsplit;
  logic [3:0]  hgrant;
  logic [3:0]  hmaster;
  logic        hmastlock;

  int checks = 0;
  int errors = 0;
  int tcount = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_rr #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .MW(4)) dut (
    .HCLK(hclk), .HRESET(hreset), .HBUSREQ(hbusreq), .HLOCK(hlock),
    .HTRANS(htrans), .HBURST(hburst), .HREADY(hready), .HRESP(hresp),
    .HSPLIT(hsplit), .HGRANT(hgrant), .HMASTER(hmaster), .HMASTLOCK(hmastlock)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        ready;
    logic [1:0]  resp;
    logic [15:0] split;
    logic [3:0]  eg;
    logic [3:0]  ehm;
    logic        eml;
    int          tid;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                     input logic [1:0] trans, input logic [2:0] burst, input logic ready,
                     input logic [1:0] resp, input logic [15:0] split,
                     input logic [3:0] eg, input logic [3:0] ehm, input logic eml,
                     input int tid);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.burst = burst;
    v.ready = ready; v.resp = resp; v.split = split;
    v.eg = eg; v.ehm = ehm; v.eml = eml; v.tid = tid;
    vecs[nvec] = v;
    nvec++;
  endtask

  // One bus cycle: drive inputs, clock, then sample 1 time unit after the edge
  task automatic apply(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst, input logic ready,
                       input logic [1:0] resp, input logic [15:0] split,
                       input logic [3:0] eg, input logic [3:0] ehm, input logic eml,
                       input int tid);
    hreset = rst; hbusreq = req; hlock = lock; htrans = trans; hburst = burst;
    hready = ready; hresp = resp; hsplit = split;
    @(posedge hclk);
    #1;
    $display("txn %0d test %0d rst=%b req=%b lock=%b trans=%b ready=%b resp=%b split=%h -> grant=%b hmaster=%0d mastlock=%b",
             tcount, tid, rst, req, lock, trans, ready, resp, split, hgrant, hmaster, hmastlock);
    checks++;
    if (hgrant !== eg) begin
      errors++;
      $display("FAIL grant txn %0d test %0d: got %b expected %b", tcount, tid, hgrant, eg);
    end
    checks++;
    if (hmaster !== ehm) begin
      errors++;
      $display("FAIL hmaster txn %0d test %0d: got %0d expected %0d", tcount, tid, hmaster, ehm);
    end
    checks++;
    if (hmastlock !== eml) begin
      errors++;
      $display("FAIL hmastlock txn %0d test %0d: got %b expected %b", tcount, tid, hmastlock, eml);
    end
    tcount++;
  endtask

  initial begin
    hreset = 1'b1; hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE;
    hready = 1'b1; hresp = OKAY; hsplit = '0;

    // 1: reset for two cycles
    add(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b0001, 0, 0, 1);
    add(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b0001, 0, 0, 1);
    // 2: all requesting, round-robin rotation, HMASTER one cycle behind
    add(0, 4'b1111, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b0010, 0, 0, 2);
    add(0, 4'b1111, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b0100, 1, 0, 2);
    add(0, 4'b1111, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b1000, 2, 0, 2);
    add(0, 4'b1111, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b0001, 3, 0, 2);
    // 3: M2 granted with HLOCK[2], held through NONSEQ/SEQ/SEQ, released on IDLE
    add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 16'h0, 4'b0010, 0, 0, 3);
    add(0, 4'b1111, 4'b0100, IDLE,   SINGLE, 1, OKAY, 16'h0, 4'b0100, 1, 0, 3);
    add(0, 4'b1111, 4'b0100, NONSEQ, SINGLE, 1, OKAY, 16'h0, 4'b0100, 2, 1, 3);
    add(0, 4'b1111, 4'b0100, SEQ,    SINGLE, 1, OKAY, 16'h0, 4'b0100, 2, 1, 3);
    add(0, 4'b1111, 4'b0100, SEQ,    SINGLE, 1, OKAY, 16'h0, 4'b0100, 2, 1, 3);
    add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 16'h0, 4'b1000, 2, 0, 3);
    // HREADY low freezes everything
    add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 0, OKAY, 16'h0, 4'b1000, 2, 0, 3);
    add(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 16'h0, 4'b0001, 3, 0, 3);
    // 4: M1 split, skipped while masked, regranted after HSPLIT[1]
    add(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0010, 0, 0, 4);
    add(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0010, 1, 0, 4);
    add(0, 4'b0011, 4'b0000, IDLE, SINGLE, 0, SPLIT, 16'h0,    4'b0010, 1, 0, 4);
    add(0, 4'b0011, 4'b0000, IDLE, SINGLE, 1, SPLIT, 16'h0,    4'b0001, 1, 0, 4);
    add(0, 4'b0011, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0001, 0, 0, 4);
    add(0, 4'b0011, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0001, 0, 0, 4);
    add(0, 4'b0011, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0002, 4'b0001, 0, 0, 4);
    add(0, 4'b0011, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0010, 0, 0, 4);
    // 5: M0 INCR4 with a BUSY inserted, M1 also requesting
    add(0, 4'b0001, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b0001, 1, 0, 5);
    add(0, 4'b0001, 4'b0000, IDLE, SINGLE, 1, OKAY, 16'h0, 4'b0001, 0, 0, 5);
`ifdef AHB_ARB_BURST_HOLD_EN
    add(0, 4'b0011, 4'b0000, NONSEQ, INCR4, 1, OKAY, 16'h0, 4'b0001, 0, 0, 5);
    add(0, 4'b0011, 4'b0000, SEQ,    INCR4, 1, OKAY, 16'h0, 4'b0001, 0, 0, 5);
    add(0, 4'b0011, 4'b0000, BUSY,   INCR4, 1, OKAY, 16'h0, 4'b0001, 0, 0, 5);
    add(0, 4'b0011, 4'b0000, SEQ,    INCR4, 1, OKAY, 16'h0, 4'b0001, 0, 0, 5);
    add(0, 4'b0011, 4'b0000, SEQ,    INCR4, 1, OKAY, 16'h0, 4'b0010, 0, 0, 5);
`else
    add(0, 4'b0011, 4'b0000, NONSEQ, INCR4, 1, OKAY, 16'h0, 4'b0010, 0, 0, 5);
    add(0, 4'b0011, 4'b0000, SEQ,    INCR4, 1, OKAY, 16'h0, 4'b0001, 1, 0, 5);
    add(0, 4'b0011, 4'b0000, BUSY,   INCR4, 1, OKAY, 16'h0, 4'b0010, 0, 0, 5);
    add(0, 4'b0011, 4'b0000, SEQ,    INCR4, 1, OKAY, 16'h0, 4'b0001, 1, 0, 5);
    add(0, 4'b0011, 4'b0000, SEQ,    INCR4, 1, OKAY, 16'h0, 4'b0010, 0, 0, 5);
`endif
    add(0, 4'b0011, 4'b0000, IDLE,   SINGLE, 1, OKAY, 16'h0, 4'b0001, 1, 0, 5);

    for (int i = 0; i < nvec; i++) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].trans, vecs[i].burst,
            vecs[i].ready, vecs[i].resp, vecs[i].split,
            vecs[i].eg, vecs[i].ehm, vecs[i].eml, vecs[i].tid);
    end

    // 6: SPLIT set and HSPLIT release of M1 in the same cycle -> stays masked
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0010, 0, 0, 6);
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0010, 1, 0, 6);
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 0, SPLIT, 16'h0002, 4'b0010, 1, 0, 6);
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, SPLIT, 16'h0,    4'b0001, 1, 0, 6);
    // HSPLIT bits above NUM_MASTERS must not release anything
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'hFFF0, 4'b0001, 0, 0, 6);
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0001, 0, 0, 6);
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0002, 4'b0001, 0, 0, 6);
    apply(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY,  16'h0,    4'b0010, 0, 0, 6);

    // 7: reset in the middle of a locked sequence abandons lock and pointer
    apply(0, 4'b0010, 4'b0010, NONSEQ, SINGLE, 1, OKAY, 16'h0, 4'b0010, 1, 1, 7);
    apply(0, 4'b1111, 4'b0010, SEQ,    SINGLE, 1, OKAY, 16'h0, 4'b0010, 1, 1, 7);
    apply(1, 4'b1111, 4'b0010, SEQ,    SINGLE, 1, OKAY, 16'h0, 4'b0001, 0, 0, 7);
    apply(0, 4'b1111, 4'b0000, SEQ,    SINGLE, 1, OKAY, 16'h0, 4'b0010, 0, 0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
